// File: rtl/bullet_pkg.sv
// Shared definitions for the bullet record table: slot geometry, record
// field offsets, colour codes, FSM state encoding and a record packer.
package bullet_pkg;

    localparam int unsigned NUM_SLOTS  = 8;
    localparam int unsigned FIRST_SLOT = 1;
    localparam int unsigned SLOT_W     = 3;
    localparam int unsigned REC_W      = 64;
    localparam int unsigned SHADOW_W   = 43;

    localparam int unsigned REC_Y_LSB     = 0;
    localparam int unsigned REC_X_LSB     = 8;
    localparam int unsigned REC_W_LSB     = 16;
    localparam int unsigned REC_H_LSB     = 24;
    localparam int unsigned REC_COLOR_LSB = 32;
    localparam int unsigned REC_RENDER    = 34;
    localparam int unsigned REC_VX_LSB    = 35;
    localparam int unsigned REC_VY_LSB    = 39;

    localparam logic [1:0] COLOR_WHITE    = 2'b00;
    localparam logic [1:0] COLOR_GREEN    = 2'b01;
    localparam logic [1:0] COLOR_BLUE     = 2'b10;
    localparam logic [1:0] COLOR_RESERVED = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    // Assemble the 43 meaningful record bits in table layout order.
    function automatic logic [SHADOW_W-1:0] pack_record(
        input logic [7:0] x,
        input logic [7:0] y,
        input logic [7:0] w,
        input logic [7:0] h,
        input logic [1:0] color,
        input logic       render,
        input logic [3:0] vx,
        input logic [3:0] vy
    );
        return {vy, vx, render, color, h, w, x, y};
    endfunction

endpackage

// File: rtl/bullet_step.sv
// Combinational single-frame move of one bullet plus the playfield kill check.
// A 9-bit sum catches both overflow past 255 and underflow below 0.
module bullet_step (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [3:0] vx,
    input  logic [3:0] vy,
    input  logic [7:0] max_x,
    input  logic [7:0] max_y,
    output logic [7:0] new_x,
    output logic [7:0] new_y,
    output logic       kill
);

    logic [8:0] sum_x;
    logic [8:0] sum_y;

    // Sign-extend velocity to 9 bits, add, and flag any out-of-field result.
    always_comb begin
        sum_x = {1'b0, x} + {{5{vx[3]}}, vx};
        sum_y = {1'b0, y} + {{5{vy[3]}}, vy};
        new_x = sum_x[7:0];
        new_y = sum_y[7:0];
        kill  = sum_x[8] | sum_y[8] | (sum_x[7:0] > max_x) | (sum_y[7:0] > max_y);
    end

endmodule

// File: rtl/bullet_writer.sv
// Write-side engine for the 8-slot bullet table: keeps the master shadow copy
// of every record, accepts spawns into free slots and sweeps all slots once
// per frame, emitting one registered 64-bit table write per cycle.
module bullet_writer
    import bullet_pkg::*;
#(
    parameter logic [7:0] FIELD_MAX_X = 8'd159,
    parameter logic [7:0] FIELD_MAX_Y = 8'd119
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        spawn_valid,
    output logic        spawn_ready,
    input  logic [7:0]  spawn_x,
    input  logic [7:0]  spawn_y,
    input  logic [7:0]  spawn_w,
    input  logic [7:0]  spawn_h,
    input  logic [1:0]  spawn_color,
    input  logic [3:0]  spawn_vx,
    input  logic [3:0]  spawn_vy,
    output logic        wr_en,
    output logic [2:0]  wr_index,
    output logic [63:0] wr_data,
    output logic        busy,
    output logic [3:0]  active_count
);

    state_t              state;
    state_t              state_next;
    logic [SLOT_W-1:0]   cnt;
    logic [SLOT_W-1:0]   cnt_next;
    logic                pend;
    logic                pend_next;

    logic [SHADOW_W-1:0] shadow [NUM_SLOTS];

    logic [SLOT_W-1:0]   proc_slot;
    logic [SHADOW_W-1:0] cur_rec;
    logic [SHADOW_W-1:0] swept_rec;
    logic                swept_kill;
    logic [7:0]          step_x;
    logic [7:0]          step_y;
    logic                step_kill;

    logic                free_found;
    logic [SLOT_W-1:0]   free_idx;

    logic                sh_we;
    logic [SLOT_W-1:0]   sh_idx;
    logic [SHADOW_W-1:0] sh_rec;

    logic                wr_en_next;
    logic [2:0]          wr_index_next;
    logic [63:0]         wr_data_next;
    logic                busy_next;
    logic [3:0]          count_next;

    // cnt holds the slot whose write is currently visible; the slot being
    // computed is one ahead, so the first write lands the cycle after the tick.
    assign proc_slot = (state == ST_IDLE) ? SLOT_W'(FIRST_SLOT) : cnt + 3'd1;
    assign cur_rec   = shadow[proc_slot];

    assign spawn_ready = (state == ST_IDLE) & ~reset & ~frame_tick & ~pend & free_found;

    bullet_step u_step (
        .x     (cur_rec[REC_X_LSB +: 8]),
        .y     (cur_rec[REC_Y_LSB +: 8]),
        .vx    (cur_rec[REC_VX_LSB +: 4]),
        .vy    (cur_rec[REC_VY_LSB +: 4]),
        .max_x (FIELD_MAX_X),
        .max_y (FIELD_MAX_Y),
        .new_x (step_x),
        .new_y (step_y),
        .kill  (step_kill)
    );

    // Lowest-numbered live slot with render clear.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = FIRST_SLOT; i < NUM_SLOTS; i++) begin
            if (!free_found && !shadow[i][REC_RENDER]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    // Sweep result for the slot being processed: move, or kill keeping old X/Y.
    always_comb begin
        swept_rec  = cur_rec;
        swept_kill = 1'b0;
        if (cur_rec[REC_RENDER]) begin
            if (step_kill) begin
                swept_rec[REC_RENDER] = 1'b0;
                swept_kill            = 1'b1;
            end else begin
                swept_rec[REC_X_LSB +: 8] = step_x;
                swept_rec[REC_Y_LSB +: 8] = step_y;
            end
        end
    end

    // Next-state, shadow write and next-output decode.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        pend_next     = pend;
        busy_next     = busy;
        count_next    = active_count;
        wr_en_next    = 1'b0;
        wr_index_next = wr_index;
        wr_data_next  = wr_data;
        sh_we         = 1'b0;
        sh_idx        = '0;
        sh_rec        = '0;

        unique case (state)
            ST_IDLE: begin
                if (frame_tick || pend) begin
                    state_next    = ST_SWEEP;
                    cnt_next      = SLOT_W'(FIRST_SLOT);
                    pend_next     = 1'b0;
                    busy_next     = 1'b1;
                    sh_we         = 1'b1;
                    sh_idx        = proc_slot;
                    sh_rec        = swept_rec;
                    wr_en_next    = 1'b1;
                    wr_index_next = proc_slot;
                    wr_data_next  = {{(REC_W - SHADOW_W){1'b0}}, swept_rec};
                    if (swept_kill) begin
                        count_next = active_count - 4'd1;
                    end
                end else if (spawn_valid && spawn_ready) begin
                    sh_we         = 1'b1;
                    sh_idx        = free_idx;
                    sh_rec        = pack_record(spawn_x, spawn_y, spawn_w, spawn_h,
                                                spawn_color, 1'b1, spawn_vx, spawn_vy);
                    wr_en_next    = 1'b1;
                    wr_index_next = free_idx;
                    wr_data_next  = {{(REC_W - SHADOW_W){1'b0}}, sh_rec};
                    count_next    = active_count + 4'd1;
                end
            end
            ST_SWEEP: begin
                if (frame_tick) begin
                    pend_next = 1'b1;
                end
                if (cnt == SLOT_W'(NUM_SLOTS - 1)) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next      = cnt + 3'd1;
                    sh_we         = 1'b1;
                    sh_idx        = proc_slot;
                    sh_rec        = swept_rec;
                    wr_en_next    = 1'b1;
                    wr_index_next = proc_slot;
                    wr_data_next  = {{(REC_W - SHADOW_W){1'b0}}, swept_rec};
                    if (swept_kill) begin
                        count_next = active_count - 4'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state, slot counter and pending-tick flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pend  <= pend_next;
        end
    end

    // Shadow record file; slot 0 is never written and stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
            end
        end else if (sh_we) begin
            shadow[sh_idx] <= sh_rec;
        end
    end

    // Registered table write port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en        <= 1'b0;
            wr_index     <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            active_count <= '0;
        end else begin
            wr_en        <= wr_en_next;
            wr_index     <= wr_index_next;
            wr_data      <= wr_data_next;
            busy         <= busy_next;
            active_count <= count_next;
        end
    end

endmodule
